alu_branch_resolve: RTL and testbench
=====================================

// Module: alu_branch_resolve
// PURPOSE
// Consumer end of the comparator path: a 2-stage pipelined branch resolver for the execute stage.
// Accepts branch ops (operands, compare funct, PC, offset, predicted direction) on a valid/ready
// handshake. Evaluates the condition and computes the branch target. Returns the resolved
// direction, redirect PC and a mispredict flag to the fetch unit. Keeps a saturating mispredict count.
// PARAMETERS
// XLEN     32  operand width for in_a/in_b
// PC_W     32  width of PC, immediate and target
// CNT_W    16  width of the saturating mispredict counter
// PORTS
// clk            in   1      clock, all state on rising edge
// rst_n          in   1      asynchronous active-low reset
// in_valid       in   1      branch op present
// in_ready       out  1      resolver can accept op this cycle
// in_a           in   XLEN   operand a
// in_b           in   XLEN   operand b
// in_funct       in   3      000 EQ, 001 NEQ, 010 UGT, 011 ULT, 100 SGT, 101 SLT, 11x illegal
// in_pc          in   PC_W   PC of branch
// in_imm         in   PC_W   signed byte offset, pre-sign-extended
// in_pred_taken  in   1      predictor's direction
// flush          in   1      synchronous kill of all in-flight ops
// out_valid      out  1      resolved result present
// out_ready      in   1      consumer accepts result
// out_taken      out  1      condition true (0 when illegal)
// out_redirect   out  PC_W   taken ? target : pc+4
// out_mispredict out  1      out_taken != pred_taken (0 when illegal)
// out_illegal    out  1      funct was 110/111
// out_misalign   out  1      taken and target[1:0] != 0
// mispred_cnt    out  CNT_W  mispredicts delivered since reset
// BEHAVIOUR
// - Reset (rst_n=0, async): s1_valid=s2_valid=0, out_valid=0, all out_* data=0, mispred_cnt=0.
//   in_ready goes to 1 on the first cycle after release.
// - Stage S1 register: captures cond, target=in_pc+in_imm, pc4=in_pc+4, pred_taken, illegal.
//   All address adds wrap mod 2^PC_W.
// - cond: EQ a==b; NEQ a!=b; UGT/ULT unsigned; SGT/SLT two's-complement signed.
// - Stage S2 register drives out_* directly. out_mispredict and out_misalign are computed S1->S2.
// - Latency: op accepted in cycle N appears on out_valid at cycle N+2 if no backpressure.
// - Throughput: 1 op/cycle.
// - s2_adv = !s2_valid | out_ready.
// - s1_adv = s2_adv.
// - in_ready = !s1_valid | s1_adv.
// - in_ready is combinational from out_ready; there is no comb path from in_valid.
// - Output hold: while out_valid=1 and out_ready=0, all out_* stay stable. S1 holds.
//   in_ready=0 once S1 is occupied.
// - flush=1 at an edge clears s1_valid and s2_valid. An op presented that cycle is dropped
//   (not accepted). The counter does not increment for a result killed by flush.
// - flush and out_ready same cycle: result is NOT counted and is discarded. flush wins.
// - mispred_cnt increments by 1 on each out_valid&out_ready&out_mispredict. It saturates at
//   2^CNT_W-1 and does not wrap.
// - Illegal funct: out_taken=0, out_mispredict=0, out_illegal=1. out_redirect=pc+4 and the
//   op still flows through.
// - Reset mid-operation: in-flight ops are lost. No output handshake occurs.
// TESTING
// - EQ a=5,b=5,pc=0x100,imm=0x20,pred=0 -> 2 cycles later: taken=1, redirect=0x120,
//   mispredict=1, cnt=1.
// - SLT a=0xFFFFFFFF,b=1 -> taken=1. ULT same operands -> taken=0.
// - pred=0, pc=0xFFFFFFFC, no-taken -> redirect=0x00000000 (wrap), mispredict=0.
// - Back-to-back 4 ops, out_ready low cycles 3-5 -> in_ready=0 after S1 fills, no loss or dup,
//   order kept, outputs stable while stalled.
// - funct=3'b110 -> illegal=1, taken=0, mispredict=0. imm=0x2 with taken -> misalign=1.
// - Pipeline full with 2 mispredicts, flush=1 -> out_valid=0 next cycle, cnt unchanged.
//   With CNT_W=2 and 5 mispredicts -> cnt=3.

Source files
------------

// File: rtl/alu_branch_resolve.sv
// alu_branch_resolve
//   Two-stage pipelined branch resolver for the execute stage. Stage S1
//   evaluates the compare condition and precomputes the taken target and the
//   fall-through PC. Stage S2 registers the resolved direction, the redirect
//   PC and the mispredict and misalign flags, and drives out_* directly. A
//   saturating counter tracks the mispredicts delivered to the fetch unit.
//
// Ports
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   in_valid/ready  op handshake; in_ready is combinational from out_ready only
//   in_a, in_b      compare operands (XLEN)
//   in_funct        000 EQ, 001 NEQ, 010 UGT, 011 ULT, 100 SGT, 101 SLT, 11x illegal
//   in_pc, in_imm   branch PC and pre-sign-extended byte offset (PC_W)
//   in_pred_taken   predicted direction
//   flush           synchronous kill of every in-flight op
//   out_valid/ready result handshake
//   out_taken       condition true (0 for an illegal funct)
//   out_redirect    taken ? target : pc+4
//   out_mispredict  out_taken != predicted direction (0 for an illegal funct)
//   out_illegal     funct was 11x
//   out_misalign    taken and target[1:0] != 0
//   mispred_cnt     saturating count of delivered mispredicts
module alu_branch_resolve #(
    parameter int XLEN  = 32,
    parameter int PC_W  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  in_a,
    input  logic [XLEN-1:0]  in_b,
    input  logic [2:0]       in_funct,
    input  logic [PC_W-1:0]  in_pc,
    input  logic [PC_W-1:0]  in_imm,
    input  logic             in_pred_taken,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_taken,
    output logic [PC_W-1:0]  out_redirect,
    output logic             out_mispredict,
    output logic             out_illegal,
    output logic             out_misalign,
    output logic [CNT_W-1:0] mispred_cnt
);

    localparam logic [2:0] F_EQ  = 3'b000;
    localparam logic [2:0] F_NEQ = 3'b001;
    localparam logic [2:0] F_UGT = 3'b010;
    localparam logic [2:0] F_ULT = 3'b011;
    localparam logic [2:0] F_SGT = 3'b100;
    localparam logic [2:0] F_SLT = 3'b101;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // S1 state
    logic            s1_valid;
    logic            s1_cond;
    logic            s1_illegal;
    logic            s1_pred;
    logic [PC_W-1:0] s1_target;
    logic [PC_W-1:0] s1_pc4;

    // Handshake; out_valid is the S2 valid bit
    logic s2_adv;
    logic s1_adv;
    logic accept;

    assign s2_adv   = !out_valid || out_ready;
    assign s1_adv   = s2_adv;
    assign in_ready = !s1_valid || s1_adv;
    // A flush cycle never accepts, so an op presented alongside it is dropped.
    assign accept   = in_valid && in_ready && !flush;

    // Condition evaluation
    logic cond_c;
    logic illegal_c;

    assign illegal_c = in_funct[2] & in_funct[1];

    always_comb begin
        // NOTE: default assignment first so every path drives cond_c and no latch is inferred.
        cond_c = 1'b0;
        case (in_funct)
            F_EQ:    cond_c = (in_a == in_b);
            F_NEQ:   cond_c = (in_a != in_b);
            F_UGT:   cond_c = (in_a > in_b);
            F_ULT:   cond_c = (in_a < in_b);
            F_SGT:   cond_c = ($signed(in_a) > $signed(in_b));
            F_SLT:   cond_c = ($signed(in_a) < $signed(in_b));
            default: cond_c = 1'b0;
        endcase
    end

    // S2 next values, derived from S1
    logic s1_taken;
    assign s1_taken = s1_cond && !s1_illegal;

    // Stage S1
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid   <= 1'b0;
            s1_cond    <= 1'b0;
            s1_illegal <= 1'b0;
            s1_pred    <= 1'b0;
            s1_target  <= '0;
            s1_pc4     <= '0;
        end else if (flush) begin
            s1_valid <= 1'b0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (accept) begin
                s1_cond    <= cond_c;
                s1_illegal <= illegal_c;
                s1_pred    <= in_pred_taken;
                // Address arithmetic wraps modulo 2^PC_W.
                s1_target  <= in_pc + in_imm;
                s1_pc4     <= in_pc + PC_W'(4);
            end
        end
    end

    // Stage S2: data only changes when a new op moves in, so it is stable under stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid      <= 1'b0;
            out_taken      <= 1'b0;
            out_redirect   <= '0;
            out_mispredict <= 1'b0;
            out_illegal    <= 1'b0;
            out_misalign   <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_taken      <= s1_taken;
                out_redirect   <= s1_taken ? s1_target : s1_pc4;
                out_mispredict <= !s1_illegal && (s1_cond != s1_pred);
                out_illegal    <= s1_illegal;
                out_misalign   <= s1_taken && (s1_target[1:0] != 2'b00);
            end
        end
    end

    // Mispredict counter: counts delivered results only; flush wins over out_ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mispred_cnt <= '0;
        end else if (!flush && out_valid && out_ready && out_mispredict
                     && mispred_cnt != CNT_MAX) begin
            mispred_cnt <= mispred_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_alu_branch_resolve.sv
// tb_alu_branch_resolve
//   Directed bench for alu_branch_resolve. Two instances share all stimulus:
//   one with the default 16-bit counter and one with CNT_W=2 to show saturation.
module tb_alu_branch_resolve;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [2:0]  in_funct;
    logic [31:0] in_pc;
    logic [31:0] in_imm;
    logic        in_pred_taken;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic        out_taken;
    logic [31:0] out_redirect;
    logic        out_mispredict;
    logic        out_illegal;
    logic        out_misalign;
    logic [15:0] mispred_cnt;

    logic        s_in_ready;
    logic        s_out_valid;
    logic        s_out_taken;
    logic [31:0] s_out_redirect;
    logic        s_out_mispredict;
    logic        s_out_illegal;
    logic        s_out_misalign;
    logic [1:0]  s_mispred_cnt;

    int checks = 0;
    int errors = 0;
    int exp_cnt = 0;

    always #5 clk = ~clk;

    alu_branch_resolve dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_funct(in_funct),
        .in_pc(in_pc), .in_imm(in_imm), .in_pred_taken(in_pred_taken),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_taken(out_taken), .out_redirect(out_redirect),
        .out_mispredict(out_mispredict), .out_illegal(out_illegal),
        .out_misalign(out_misalign), .mispred_cnt(mispred_cnt)
    );

    alu_branch_resolve #(.CNT_W(2)) dut_small (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(s_in_ready),
        .in_a(in_a), .in_b(in_b), .in_funct(in_funct),
        .in_pc(in_pc), .in_imm(in_imm), .in_pred_taken(in_pred_taken),
        .flush(flush),
        .out_valid(s_out_valid), .out_ready(out_ready),
        .out_taken(s_out_taken), .out_redirect(s_out_redirect),
        .out_mispredict(s_out_mispredict), .out_illegal(s_out_illegal),
        .out_misalign(s_out_misalign), .mispred_cnt(s_mispred_cnt)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_cnt(input string tag);
        check({tag, "_cnt"}, 64'(mispred_cnt), 64'(exp_cnt));
        check({tag, "_cnt2"}, 64'(s_mispred_cnt), 64'((exp_cnt > 3) ? 3 : exp_cnt));
    endtask

    task automatic drive(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] pc, input logic [31:0] imm, input logic pred);
        in_valid      = 1'b1;
        in_funct      = f;
        in_a          = a;
        in_b          = b;
        in_pc         = pc;
        in_imm        = imm;
        in_pred_taken = pred;
    endtask

    // Single op through an idle pipeline with out_ready held high.
    task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] pc, input logic [31:0] imm,
                          input logic pred, input logic et, input logic [31:0] er,
                          input logic em, input logic ei, input logic ea);
        out_ready = 1'b1;
        drive(f, a, b, pc, imm, pred);
        #1;
        check({tag, "_in_ready"}, 64'(in_ready), 64'(1));
        step();
        in_valid = 1'b0;
        check({tag, "_lat1_valid"}, 64'(out_valid), 64'(0));
        step();
        check({tag, "_valid"},      64'(out_valid),      64'(1));
        check({tag, "_taken"},      64'(out_taken),      64'(et));
        check({tag, "_redirect"},   64'(out_redirect),   64'(er));
        check({tag, "_mispredict"}, 64'(out_mispredict), 64'(em));
        check({tag, "_illegal"},    64'(out_illegal),    64'(ei));
        check({tag, "_misalign"},   64'(out_misalign),   64'(ea));
        step();
        if (em) exp_cnt++;
        check({tag, "_drained"}, 64'(out_valid), 64'(0));
        check_cnt(tag);
    endtask

    typedef struct {
        logic [2:0]  f;
        logic [31:0] a, b, pc, imm;
        logic        pred;
        logic        et;
        logic [31:0] er;
        logic        em;
    } op_t;

    op_t ops[4];

    initial begin
        rst_n         = 1'b0;
        in_valid      = 1'b0;
        in_a          = '0;
        in_b          = '0;
        in_funct      = '0;
        in_pc         = '0;
        in_imm        = '0;
        in_pred_taken = 1'b0;
        flush         = 1'b0;
        out_ready     = 1'b0;

        // Reset state
        #23;
        check("rst_out_valid", 64'(out_valid),    64'(0));
        check("rst_redirect",  64'(out_redirect), 64'(0));
        check("rst_taken",     64'(out_taken),    64'(0));
        check_cnt("rst");
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("rst_in_ready", 64'(in_ready), 64'(1));

        // Directed single ops: funct, a, b, pc, imm, pred, taken, redirect, mis, ill, misal
        run_op("eq_taken",  3'b000, 32'd5, 32'd5, 32'h100, 32'h20, 1'b0, 1'b1, 32'h120, 1'b1, 1'b0, 1'b0);
        run_op("slt_neg",   3'b101, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h40, 1'b1, 1'b1, 32'h240, 1'b0, 1'b0, 1'b0);
        run_op("ult_neg",   3'b011, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h40, 1'b1, 1'b0, 32'h204, 1'b1, 1'b0, 1'b0);
        run_op("pc_wrap",   3'b001, 32'd3, 32'd3, 32'hFFFF_FFFC, 32'h10, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        run_op("illegal",   3'b110, 32'd1, 32'd1, 32'h300, 32'h8, 1'b1, 1'b0, 32'h304, 1'b0, 1'b1, 1'b0);
        run_op("misalign",  3'b000, 32'd7, 32'd7, 32'h400, 32'h2, 1'b1, 1'b1, 32'h402, 1'b0, 1'b0, 1'b1);
        run_op("ugt_back",  3'b010, 32'h8000_0000, 32'd1, 32'h500, 32'hFFFF_FFF8, 1'b0, 1'b1, 32'h4F8, 1'b1, 1'b0, 1'b0);
        run_op("sgt_neg",   3'b100, 32'h8000_0000, 32'd1, 32'h500, 32'hFFFF_FFF8, 1'b1, 1'b0, 32'h504, 1'b1, 1'b0, 1'b0);

        // Back-to-back stream with out_ready low in cycles 3..5
        ops[0] = '{3'b000, 32'd1, 32'd1, 32'h1000, 32'h10, 1'b1, 1'b1, 32'h1010, 1'b0};
        ops[1] = '{3'b001, 32'd1, 32'd2, 32'h1004, 32'h20, 1'b0, 1'b1, 32'h1024, 1'b1};
        ops[2] = '{3'b011, 32'd5, 32'd3, 32'h1008, 32'h30, 1'b0, 1'b0, 32'h100C, 1'b0};
        ops[3] = '{3'b101, 32'd3, 32'd5, 32'h100C, 32'h44, 1'b0, 1'b1, 32'h1050, 1'b1};
        begin
            int sent = 0;
            int recv = 0;
            logic        stall;
            logic        hs;
            logic        acc;
            logic        h_taken;
            logic        h_mis;
            logic [31:0] h_redir;
            for (int c = 0; c < 30 && recv < 4; c++) begin
                out_ready = !(c >= 3 && c <= 5);
                if (sent < 4)
                    drive(ops[sent].f, ops[sent].a, ops[sent].b, ops[sent].pc,
                          ops[sent].imm, ops[sent].pred);
                else
                    in_valid = 1'b0;
                #1;
                if (c == 3) check("b2b_in_ready_stall", 64'(in_ready), 64'(0));
                acc     = in_valid && in_ready;
                hs      = out_valid && out_ready;
                stall   = out_valid && !out_ready;
                h_taken = out_taken;
                h_mis   = out_mispredict;
                h_redir = out_redirect;
                if (hs) begin
                    if (recv < 4) begin
                        check("b2b_taken",    64'(out_taken),      64'(ops[recv].et));
                        check("b2b_redirect", 64'(out_redirect),   64'(ops[recv].er));
                        check("b2b_mis",      64'(out_mispredict), 64'(ops[recv].em));
                        if (ops[recv].em) exp_cnt++;
                    end else begin
                        check("b2b_extra_result", 64'(1), 64'(0));
                    end
                    recv++;
                end
                step();
                if (acc) sent++;
                if (stall) begin
                    check("b2b_hold_valid",  64'(out_valid),      64'(1));
                    check("b2b_hold_taken",  64'(out_taken),      64'(h_taken));
                    check("b2b_hold_mis",    64'(out_mispredict), 64'(h_mis));
                    check("b2b_hold_redir",  64'(out_redirect),   64'(h_redir));
                end
            end
            in_valid = 1'b0;
            check("b2b_recv_count", 64'(recv), 64'(4));
            step();
            check("b2b_empty", 64'(out_valid), 64'(0));
            check_cnt("b2b");
        end

        // Flush with two mispredicts in flight, plus an op offered in the flush cycle
        out_ready = 1'b0;
        drive(3'b000, 32'd1, 32'd1, 32'h2000, 32'h10, 1'b0);
        step();
        drive(3'b000, 32'd2, 32'd2, 32'h2004, 32'h10, 1'b0);
        step();
        in_valid = 1'b0;
        check("flush_full_valid", 64'(out_valid), 64'(1));
        check("flush_full_mis",   64'(out_mispredict), 64'(1));
        out_ready = 1'b1;
        flush     = 1'b1;
        drive(3'b000, 32'd3, 32'd3, 32'h2008, 32'h10, 1'b0);
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_out_valid", 64'(out_valid), 64'(0));
        check_cnt("flush");
        step();
        step();
        check("flush_dropped", 64'(out_valid), 64'(0));
        check_cnt("flush_after");

        // More mispredicts: the 2-bit counter stays saturated
        run_op("sat_a", 3'b001, 32'd4, 32'd4, 32'h3000, 32'h8, 1'b1, 1'b0, 32'h3004, 1'b1, 1'b0, 1'b0);
        run_op("sat_b", 3'b000, 32'd4, 32'd4, 32'h3000, 32'h8, 1'b0, 1'b1, 32'h3008, 1'b1, 1'b0, 1'b0);

        // Reset with an op in flight: result lost, counter cleared
        out_ready = 1'b0;
        drive(3'b000, 32'd9, 32'd9, 32'h4000, 32'h4, 1'b0);
        step();
        in_valid = 1'b0;
        step();
        check("midrst_pre_valid", 64'(out_valid), 64'(1));
        #2;
        rst_n = 1'b0;
        #1;
        exp_cnt = 0;
        check("midrst_valid", 64'(out_valid), 64'(0));
        check_cnt("midrst");
        #3;
        rst_n = 1'b1;
        out_ready = 1'b1;
        step();
        step();
        check("midrst_no_result", 64'(out_valid), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
